// File: rtl/mac_sequencer.sv
// Operand sequencer for a Q8.8 MAC: buffers A/B operands, streams len pairs into the
// MAC after a clear, issues the pipeline flush, then captures the dot product.
module mac_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [15:0]   wr_a_i,
    input  logic [15:0]   wr_b_i,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [15:0]   result_o,
    output logic          mac_rst_o,
    output logic          mac_run_o,
    output logic [15:0]   mac_a_o,
    output logic [15:0]   mac_b_o,
    input  logic [15:0]   mac_y_i,
    output logic [2:0]    dbg_state_o,
    output logic [AW-1:0] dbg_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_STREAM  = 3'd2,
        S_FLUSH   = 3'd3,
        S_CAPTURE = 3'd4
    } state_e;

    localparam logic [AW:0]   LEN_MAX = DEPTH[AW:0];
    localparam logic [AW:0]   LEN_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] IDX_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic          mac_rst_q, mac_rst_d;
    logic          mac_run_q, mac_run_d;
    logic [15:0]   mac_a_q, mac_a_d;
    logic [15:0]   mac_b_q, mac_b_d;
    logic          done_q, done_d;
    logic [15:0]   result_q, result_d;

    logic [15:0]   buf_a_q [DEPTH];
    logic [15:0]   buf_b_q [DEPTH];

    logic [AW:0]   len_clamped;
    logic [AW-1:0] idx_inc;
    logic          last_pair;

    assign len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;
    assign idx_inc     = idx_q + IDX_ONE;
    assign last_pair   = ({1'b0, idx_q} == (len_q - LEN_ONE));

    // Operand buffers are plain storage: written only in IDLE, never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && (state_q == S_IDLE)) begin
            buf_a_q[wr_addr_i] <= wr_a_i;
            buf_b_q[wr_addr_i] <= wr_b_i;
        end
    end

    // Outputs are registered from the next state, so each mac_* value is
    // presented during the cycle of the state that owns it.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        mac_rst_d = 1'b1;
        mac_run_d = 1'b0;
        mac_a_d   = 16'h0000;
        mac_b_d   = 16'h0000;
        done_d    = 1'b0;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d     = len_clamped;
                    idx_d     = '0;
                    state_d   = S_CLEAR;
                    mac_rst_d = 1'b0;
                end
            end
            S_CLEAR: begin
                mac_run_d = 1'b1;
                if (len_q != '0) begin
                    state_d = S_STREAM;
                    mac_a_d = buf_a_q[{AW{1'b0}}];
                    mac_b_d = buf_b_q[{AW{1'b0}}];
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_STREAM: begin
                mac_run_d = 1'b1;
                if (last_pair) begin
                    state_d = S_FLUSH;
                end else begin
                    idx_d   = idx_inc;
                    mac_a_d = buf_a_q[idx_inc];
                    mac_b_d = buf_b_q[idx_inc];
                end
            end
            S_FLUSH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d  = S_IDLE;
                done_d   = 1'b1;
                result_d = mac_y_i;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            mac_rst_q <= 1'b0;
            mac_run_q <= 1'b0;
            mac_a_q   <= 16'h0000;
            mac_b_q   <= 16'h0000;
            done_q    <= 1'b0;
            result_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            mac_rst_q <= mac_rst_d;
            mac_run_q <= mac_run_d;
            mac_a_q   <= mac_a_d;
            mac_b_q   <= mac_b_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign mac_rst_o   = mac_rst_q;
    assign mac_run_o   = mac_run_q;
    assign mac_a_o     = mac_a_q;
    assign mac_b_o     = mac_b_q;
    assign dbg_state_o = state_q;
    assign dbg_idx_o   = idx_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Testbench for mac_sequencer: behavioural MAC, table vectors, corner sequences,
// and randomized runs checked against a dot-product reference.
module tb_mac_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_a, wr_b;
    logic          start;
    logic [AW:0]   len;
    logic          busy, done, mac_rst, mac_run;
    logic [15:0]   result, mac_a, mac_b, mac_y;
    logic [2:0]    dbg_state;
    logic [AW-1:0] dbg_idx;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sha_a [DEPTH];
    logic [15:0] sha_b [DEPTH];

    mac_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_a_i(wr_a), .wr_b_i(wr_b), .start_i(start), .len_i(len),
        .busy_o(busy), .done_o(done), .result_o(result), .mac_rst_o(mac_rst),
        .mac_run_o(mac_run), .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_y_i(mac_y),
        .dbg_state_o(dbg_state), .dbg_idx_o(dbg_idx)
    );

    always #5 clk = ~clk;

    // Behavioural MAC: one-cycle product register feeding a wide accumulator.
    logic signed [31:0] m_prod;
    logic signed [39:0] m_sum;
    always @(posedge clk) begin
        if (!mac_rst) begin
            m_prod <= 0;
            m_sum  <= 0;
        end else if (mac_run) begin
            m_prod <= $signed(mac_a) * $signed(mac_b);
            m_sum  <= m_sum + m_prod;
        end
    end
    assign mac_y = m_sum[23:8];

    typedef struct {
        int                wn;
        logic [15:0][15:0] va;
        logic [15:0][15:0] vb;
        logic [4:0]        l;
        bit                coll;
        logic [3:0]        caddr;
        logic [15:0]       ca, cb;
        logic [15:0]       exp_res;
        int                exp_lat;
        int                exp_runs;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_dot(input int n);
        longint s;
        int     m;
        s = 0;
        m = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < m; i++)
            s += longint'($signed(sha_a[i])) * longint'($signed(sha_b[i]));
        return s[23:8];
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic write_pair(input logic [3:0] addr, input logic [15:0] a, input logic [15:0] b);
        wr_en = 1'b1; wr_addr = addr; wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
        sha_a[addr] = a;
        sha_b[addr] = b;
    endtask

    task automatic run_dot(input logic [4:0] l, input bit coll, input logic [3:0] caddr,
                           input logic [15:0] ca, input logic [15:0] cb, input bit poke,
                           output logic [15:0] res, output int lat, output int runs,
                           output int nz_ops, output bit busy_ok, output bit contig);
        int first_k, last_k;
        start = 1'b1; len = l;
        if (coll) begin
            wr_en = 1'b1; wr_addr = caddr; wr_a = ca; wr_b = cb;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        if (coll) begin
            sha_a[caddr] = ca;
            sha_b[caddr] = cb;
        end
        busy_ok = busy;
        lat = -1; runs = 0; nz_ops = 0; res = 16'h0000;
        first_k = -1; last_k = -1;
        for (int k = 1; k <= 60; k++) begin
            if (poke && k == 1) begin
                start = 1'b1; len = 5'd2;
                wr_en = 1'b1; wr_addr = '0; wr_a = 16'h7FFF; wr_b = 16'h7FFF;
            end
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            if (mac_run) begin
                runs++;
                if (first_k < 0) first_k = k;
                last_k = k;
                if (mac_a != 16'h0 || mac_b != 16'h0) nz_ops++;
            end
            if (done) begin
                lat = k;
                res = result;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        contig = (runs > 0) && (last_k - first_k + 1 == runs);
    endtask

    task automatic run_and_check(input string nm, input logic [4:0] l, input bit coll,
                                 input logic [3:0] caddr, input logic [15:0] ca,
                                 input logic [15:0] cb, input bit poke, input logic [15:0] exp_res);
        logic [15:0] res;
        int lat, runs, nz, eff;
        bit bok, cont;
        eff = (l > DEPTH) ? DEPTH : int'(l);
        run_dot(l, coll, caddr, ca, cb, poke, res, lat, runs, nz, bok, cont);
        chk({nm, " result"}, 32'(res), 32'(exp_res));
        chk({nm, " latency"}, 32'(lat), 32'(eff + 3));
        chk({nm, " run_cycles"}, 32'(runs), 32'(eff + 1));
        chk({nm, " run_contiguous"}, 32'(cont), 32'd1);
        chk({nm, " busy_window"}, 32'(bok), 32'd1);
        if (eff == 0) chk({nm, " flush_zero_ops"}, 32'(nz), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] r;
        int          done_seen;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        start = 1'b0; len = '0;

        // Table: single pair, signed, len=0, clamp, collision on start edge.
        for (int i = 0; i < 5; i++) begin
            vecs[i].wn = 0; vecs[i].va = '0; vecs[i].vb = '0; vecs[i].coll = 1'b0;
            vecs[i].caddr = '0; vecs[i].ca = '0; vecs[i].cb = '0;
        end
        vecs[0].wn = 1; vecs[0].va[0] = 16'h0180; vecs[0].vb[0] = 16'h0200;
        vecs[0].l = 5'd1; vecs[0].exp_res = 16'h0300; vecs[0].exp_lat = 4; vecs[0].exp_runs = 2;
        vecs[1].wn = 3;
        vecs[1].va[0] = 16'h0180; vecs[1].vb[0] = 16'h0200;
        vecs[1].va[1] = 16'hFF00; vecs[1].vb[1] = 16'h0200;
        vecs[1].va[2] = 16'h0080; vecs[1].vb[2] = 16'h0080;
        vecs[1].l = 5'd3; vecs[1].exp_res = 16'h0140; vecs[1].exp_lat = 6; vecs[1].exp_runs = 4;
        vecs[2].l = 5'd0; vecs[2].exp_res = 16'h0000; vecs[2].exp_lat = 3; vecs[2].exp_runs = 1;
        vecs[3].wn = 16;
        for (int i = 0; i < 16; i++) begin vecs[3].va[i] = 16'h0100; vecs[3].vb[i] = 16'h0100; end
        vecs[3].l = 5'd31; vecs[3].exp_res = 16'h1000; vecs[3].exp_lat = 19; vecs[3].exp_runs = 17;
        vecs[4] = vecs[3];
        vecs[4].l = 5'd16; vecs[4].coll = 1'b1; vecs[4].caddr = 4'd5;
        vecs[4].ca = 16'h0200; vecs[4].cb = 16'h0100; vecs[4].exp_res = 16'h1100;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset mac_rst", 32'(mac_rst), 32'd0);
        chk("reset mac_run", 32'(mac_run), 32'd0);
        chk("reset mac_ab", {mac_a, mac_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset mac_rst", 32'(mac_rst), 32'd1);

        for (int i = 0; i < DEPTH; i++) write_pair(4'(i), 16'h0000, 16'h0000);

        // Table-driven vectors
        for (int v = 0; v < 5; v++) begin
            logic [15:0] res;
            int lat, runs, nz;
            bit bok, cont;
            for (int i = 0; i < vecs[v].wn; i++) write_pair(4'(i), vecs[v].va[i], vecs[v].vb[i]);
            run_dot(vecs[v].l, vecs[v].coll, vecs[v].caddr, vecs[v].ca, vecs[v].cb, 1'b0,
                    res, lat, runs, nz, bok, cont);
            chk($sformatf("vec%0d result", v), 32'(res), 32'(vecs[v].exp_res));
            chk($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            chk($sformatf("vec%0d run_cycles", v), 32'(runs), 32'(vecs[v].exp_runs));
            chk($sformatf("vec%0d run_contiguous", v), 32'(cont), 32'd1);
            chk($sformatf("vec%0d busy_window", v), 32'(bok), 32'd1);
            if (vecs[v].l == 0) chk($sformatf("vec%0d flush_zero_ops", v), 32'(nz), 32'd0);
        end

        // Blocking while busy, then back-to-back restart from a cleared MAC
        write_pair(4'd0, 16'h0180, 16'h0200);
        write_pair(4'd1, 16'hFF00, 16'h0200);
        write_pair(4'd2, 16'h0080, 16'h0080);
        run_and_check("blocked", 5'd3, 1'b0, '0, '0, '0, 1'b1, 16'h0140);
        run_and_check("back_to_back", 5'd3, 1'b0, '0, '0, '0, 1'b0, 16'h0140);

        // Randomized runs against the reference dot product
        for (int it = 0; it < 14; it++) begin
            int nw;
            logic [4:0] l;
            bit coll, poke;
            logic [3:0] ca_addr;
            logic [15:0] ca, cb;
            nw = $urandom_range(1, 16);
            for (int j = 0; j < nw; j++)
                write_pair(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
            l = 5'($urandom_range(0, 31));
            coll = 1'($urandom_range(0, 1));
            poke = 1'($urandom_range(0, 1));
            ca_addr = 4'($urandom_range(0, 15));
            ca = 16'($urandom); cb = 16'($urandom);
            if (coll) begin
                sha_a[ca_addr] = ca;
                sha_b[ca_addr] = cb;
            end
            r = ref_dot(int'(l));
            run_and_check($sformatf("rand%0d", it), l, coll, ca_addr, ca, cb, poke, r);
        end

        // Reset in the middle of STREAM
        for (int i = 0; i < DEPTH; i++) write_pair(4'(i), 16'h0100, 16'h0300);
        r = ref_dot(16);
        run_and_check("pre_abort", 5'd16, 1'b0, '0, '0, '0, 1'b0, r);
        start = 1'b1; len = 5'd16;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort precondition mac_run", 32'(mac_run), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort mac_run", 32'(mac_run), 32'd0);
        chk("abort mac_rst", 32'(mac_rst), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort mac_ab", {mac_a, mac_b}, 32'd0);
        done_seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort no_done", 32'(done_seen), 32'd0);
        chk("abort mac_cleared", 32'(mac_y), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort release mac_rst", 32'(mac_rst), 32'd1);
        run_and_check("post_abort", 5'd16, 1'b0, '0, '0, '0, 1'b0, r);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
